// File: rtl/parking_gate_if.sv
// parking_gate_if: gate request/response and datapath command bundle; master = requesters/observer, slave = scheduler
interface parking_gate_if;
  logic       entry_req;
  logic [1:0] entry_id;
  logic       exit_req;
  logic [1:0] exit_id;
  logic       car_enter;
  logic       car_exit;
  logic [2:0] car_sel;
  logic       entry_ack;
  logic       entry_rej;
  logic       exit_ack;
  logic       exit_rej;
  logic       gate_in_open;
  logic       gate_out_open;
  logic [2:0] occupied;
  logic       full;
  logic       busy;
  modport master (
    output entry_req, entry_id, exit_req, exit_id,
    input  car_enter, car_exit, car_sel, entry_ack, entry_rej, exit_ack, exit_rej,
           gate_in_open, gate_out_open, occupied, full, busy
  );
  modport slave (
    input  entry_req, entry_id, exit_req, exit_id,
    output car_enter, car_exit, car_sel, entry_ack, entry_rej, exit_ack, exit_rej,
           gate_in_open, gate_out_open, occupied, full, busy
  );
endinterface

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: round-robin entry/exit gate arbiter with occupancy check, one-cycle command pulse and timed barrier; ports clk, reset (async high), bus (parking_gate_if.slave)
module parking_gate_scheduler #(
  parameter int          CAPACITY    = 2,
  parameter logic [15:0] GATE_CYCLES = 16'd50
) (
  input logic            clk,
  input logic            reset,
  parking_gate_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_REJ  = 2'd2;
  localparam logic [1:0] S_GATE = 2'd3;
  logic [1:0]  r_state;
  logic        r_exit;
  logic        r_last;
  logic [2:0]  r_oh;
  logic [2:0]  r_occ;
  logic [15:0] r_cnt;
  logic [2:0]  w_entry_oh;
  logic [2:0]  w_exit_oh;
  logic [1:0]  w_cars;
  logic        w_full;
  logic        w_pick_exit;
  logic [2:0]  w_oh;
  logic        w_ok;
  logic [15:0] w_load;
  assign w_entry_oh  = 3'b001 << (bus.entry_id - 2'd1);
  assign w_exit_oh   = 3'b001 << (bus.exit_id - 2'd1);
  assign w_cars      = 2'(r_occ[0]) + 2'(r_occ[1]) + 2'(r_occ[2]);
  assign w_full      = int'(w_cars) >= CAPACITY;
  assign w_pick_exit = bus.exit_req & (~bus.entry_req | ~r_last);
  assign w_oh        = w_pick_exit ? w_exit_oh : w_entry_oh;
  assign w_ok        = w_pick_exit ? |(w_exit_oh & r_occ)
                                   : (|w_entry_oh & ~|(w_entry_oh & r_occ) & ~w_full);
  assign w_load      = (GATE_CYCLES == 16'd0) ? 16'd1 : GATE_CYCLES;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_exit  <= 1'b0;
      r_last  <= 1'b0;
      r_oh    <= 3'b000;
      r_occ   <= 3'b000;
      r_cnt   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.entry_req | bus.exit_req) begin
          r_exit  <= w_pick_exit;
          r_last  <= w_pick_exit;
          r_oh    <= w_oh;
          r_state <= w_ok ? S_CMD : S_REJ;
        end
        S_CMD: begin
          r_occ   <= r_exit ? (r_occ & ~r_oh) : (r_occ | r_oh);
          r_cnt   <= w_load;
          r_state <= S_GATE;
        end
        S_REJ: r_state <= S_IDLE;
        default: begin
          r_cnt   <= r_cnt - 16'd1;
          r_state <= (r_cnt == 16'd1) ? S_IDLE : S_GATE;
        end
      endcase
    end
  end
  assign bus.car_enter     = (r_state == S_CMD) & ~r_exit;
  assign bus.car_exit      = (r_state == S_CMD) & r_exit;
  assign bus.car_sel       = (r_state == S_CMD) ? r_oh : 3'b000;
  assign bus.entry_ack     = (r_state == S_CMD) & ~r_exit;
  assign bus.exit_ack      = (r_state == S_CMD) & r_exit;
  assign bus.entry_rej     = (r_state == S_REJ) & ~r_exit;
  assign bus.exit_rej      = (r_state == S_REJ) & r_exit;
  assign bus.gate_in_open  = (r_state == S_GATE) & ~r_exit;
  assign bus.gate_out_open = (r_state == S_GATE) & r_exit;
  assign bus.occupied      = r_occ;
  assign bus.full          = w_full;
  assign bus.busy          = r_state != S_IDLE;
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb_parking_gate_scheduler: directed checks of arbitration, validation, gate timing and reset
module tb_parking_gate_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   g;
  always #5 clk = ~clk;
  parking_gate_if ia();
  parking_gate_if ib();
  parking_gate_scheduler dut_a (.clk(clk), .reset(reset), .bus(ia));
  parking_gate_scheduler #(.GATE_CYCLES(16'd0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic req_a(input logic is_exit, input logic [1:0] id);
    @(negedge clk);
    if (is_exit) begin
      ia.exit_req = 1'b1;
      ia.exit_id  = id;
    end else begin
      ia.entry_req = 1'b1;
      ia.entry_id  = id;
    end
    @(negedge clk);
  endtask
  task automatic drop_a();
    ia.entry_req = 1'b0;
    ia.exit_req  = 1'b0;
  endtask
  task automatic wait_a(output int gc);
    gc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ia.busy) return;
      gc += int'(ia.gate_in_open) + int'(ia.gate_out_open);
    end
    check("idle_timeout", 16'(ia.busy), 16'd0);
  endtask
  initial begin
    ia.entry_req = 1'b0; ia.entry_id = 2'd0; ia.exit_req = 1'b0; ia.exit_id = 2'd0;
    ib.entry_req = 1'b0; ib.entry_id = 2'd0; ib.exit_req = 1'b0; ib.exit_id = 2'd0;
    reset = 1'b1;
    #12;
    check("rst_busy", 16'(ia.busy), 16'd0);
    check("rst_occ", 16'(ia.occupied), 16'd0);
    check("rst_gate", 16'({ia.gate_in_open, ia.gate_out_open}), 16'd0);
    check("rst_sel", 16'(ia.car_sel), 16'd0);
    @(negedge clk) reset = 1'b0;
    req_a(1'b0, 2'd1);
    check("e1_enter", 16'(ia.car_enter), 16'd1);
    check("e1_sel", 16'(ia.car_sel), 16'd1);
    check("e1_ackrej", 16'({ia.entry_ack, ia.entry_rej}), 16'b10);
    drop_a();
    wait_a(g);
    check("e1_gate_cycles", 16'(g), 16'd50);
    check("e1_occ", 16'(ia.occupied), 16'd1);
    check("e1_full", 16'(ia.full), 16'd0);
    req_a(1'b0, 2'd2);
    check("e2_ack", 16'(ia.entry_ack), 16'd1);
    drop_a();
    wait_a(g);
    check("e2_full", 16'(ia.full), 16'd1);
    req_a(1'b0, 2'd3);
    check("e3_rej", 16'({ia.entry_rej, ia.car_enter, ia.entry_ack}), 16'b100);
    drop_a();
    wait_a(g);
    check("e3_gate", 16'(g), 16'd0);
    check("e3_occ", 16'(ia.occupied), 16'd3);
    @(negedge clk);
    ia.entry_req = 1'b1; ia.entry_id = 2'd3;
    ia.exit_req  = 1'b1; ia.exit_id  = 2'd1;
    @(negedge clk);
    check("rr_exit", 16'({ia.car_exit, ia.exit_ack, ia.car_enter, ia.entry_ack}), 16'b1100);
    check("rr_exit_sel", 16'(ia.car_sel), 16'd1);
    ia.exit_req = 1'b0;
    wait_a(g);
    check("rr_exit_gate", 16'(g), 16'd50);
    @(negedge clk);
    check("rr_entry", 16'({ia.car_enter, ia.entry_ack}), 16'b11);
    check("rr_entry_sel", 16'(ia.car_sel), 16'd4);
    drop_a();
    wait_a(g);
    check("rr_occ", 16'(ia.occupied), 16'd6);
    req_a(1'b1, 2'd1);
    check("x1_rej", 16'({ia.exit_rej, ia.car_exit, ia.exit_ack}), 16'b100);
    drop_a();
    wait_a(g);
    req_a(1'b0, 2'd0);
    check("e0_rej", 16'({ia.entry_rej, ia.car_enter}), 16'b10);
    drop_a();
    wait_a(g);
    check("rej_occ", 16'(ia.occupied), 16'd6);
    req_a(1'b1, 2'd2);
    check("x2_ack", 16'({ia.exit_ack, ia.car_exit, ia.car_sel}), 16'b11010);
    drop_a();
    wait_a(g);
    check("x2_occ", 16'(ia.occupied), 16'd4);
    req_a(1'b0, 2'd1);
    check("e1b_ack", 16'(ia.entry_ack), 16'd1);
    drop_a();
    repeat (5) @(negedge clk);
    check("mid_gate", 16'(ia.gate_in_open), 16'd1);
    reset = 1'b1;
    #1;
    check("mid_rst", 16'({ia.gate_in_open, ia.busy, ia.occupied}), 16'd0);
    @(negedge clk) reset = 1'b0;
    req_a(1'b0, 2'd1);
    check("post_rst_ack", 16'({ia.entry_ack, ia.car_sel}), 16'b1001);
    drop_a();
    wait_a(g);
    check("post_rst_gate", 16'(g), 16'd50);
    check("post_rst_occ", 16'(ia.occupied), 16'd1);
    @(negedge clk);
    ib.entry_req = 1'b1; ib.entry_id = 2'd2;
    @(negedge clk);
    check("g0_ack", 16'({ib.entry_ack, ib.car_enter, ib.car_sel}), 16'b11010);
    @(negedge clk);
    check("g0_open", 16'(ib.gate_in_open), 16'd1);
    @(negedge clk);
    check("g0_closed", 16'({ib.gate_in_open, ib.busy}), 16'd0);
    @(negedge clk);
    check("g0_dup_rej", 16'({ib.entry_rej, ib.car_enter, ib.entry_ack}), 16'b100);
    ib.entry_req = 1'b0;
    @(negedge clk);
    check("g0_occ", 16'({ib.busy, ib.occupied}), 16'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
